serial_alu: RTL and testbench

//  Multi-cycle, parametrised ALU that processes A/B in DIGIT-bit chunks, LSB first, one chunk per clock.

---
 rtl/serial_alu.sv | 150 +++++++++++++++
 tb/tb_serial_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Digit-serial ALU: processes A/B DIGIT bits per clock, LSB first, behind a start/done handshake.
// Same OP encoding and carry/overflow/SLT rules as the single-cycle ripple-slice ALU.
module serial_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             c_out,
    output logic             V,
    output logic             zero
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, r_q, r_d;
    logic [2:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d, cmsb_q, cmsb_d;
    logic             cout_q, cout_d, v_q, v_d, zero_q, zero_d, done_q, done_d;

    logic [DIGIT-1:0] da, db, dsum, dres;
    logic             c_into_top, c_digit_out;
    logic             v_fin, set_fin;
    logic [WIDTH-1:0] r_fin;

    // One DIGIT-wide ripple slice, fed by the carry register.
    always_comb begin : p_digit
        logic c;
        da         = a_q[DIGIT-1:0];
        db         = b_q[DIGIT-1:0] ^ {DIGIT{op_q[2]}};
        dsum       = '0;
        c          = carry_q;
        c_into_top = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) c_into_top = c;
            dsum[i] = da[i] ^ db[i] ^ c;
            c       = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
        end
        c_digit_out = c;
        dres = op_q[1] ? dsum : (op_q[0] ? (da | db) : (da & db));
    end

    // In DONE the shift register holds the full sum for OP[1]=1, so its MSB is the sum sign.
    always_comb begin
        v_fin   = cmsb_q ^ carry_q;
        set_fin = sh_q[WIDTH-1] ^ v_fin;
        r_fin   = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, set_fin} : sh_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        r_d     = r_q;
        cout_d  = cout_q;
        v_d     = v_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = OP;
                    carry_d = OP[2];
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sh_d    = (sh_q >> DIGIT) | (WIDTH'(dres) << (WIDTH - DIGIT));
                carry_d = c_digit_out;
                if (cnt_q == CntW'(NDIG - 1)) begin
                    cmsb_d  = c_into_top;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                r_d     = r_fin;
                cout_d  = carry_q;
                v_d     = v_fin;
                zero_d  = (r_fin == '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == StIdle) && !reset;
    assign done  = done_q;
    assign R     = r_q;
    assign c_out = cout_q;
    assign V     = v_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Runs three serial_alu instances (DIGIT = 4, 1, 32) side by side on shared operands and
// compares results, latency and done pulses against directed vectors and an arithmetic model.
module tb_serial_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, start_x, start4;
    logic [31:0]       a, b;
    logic [2:0]        op;
    logic [2:0]        ready_w, done_w, c_w, v_w, z_w;
    logic [2:0][31:0]  r_w;

    assign start4 = start | start_x;

    serial_alu #(.WIDTH(32), .DIGIT(4)) u_dig4 (
        .clk(clk), .reset(reset), .start(start4), .A(a), .B(b), .OP(op),
        .ready(ready_w[0]), .done(done_w[0]), .R(r_w[0]), .c_out(c_w[0]), .V(v_w[0]),
        .zero(z_w[0])
    );
    serial_alu #(.WIDTH(32), .DIGIT(1)) u_dig1 (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .OP(op),
        .ready(ready_w[1]), .done(done_w[1]), .R(r_w[1]), .c_out(c_w[1]), .V(v_w[1]),
        .zero(z_w[1])
    );
    serial_alu #(.WIDTH(32), .DIGIT(32)) u_dig32 (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .OP(op),
        .ready(ready_w[2]), .done(done_w[2]), .R(r_w[2]), .c_out(c_w[2]), .V(v_w[2]),
        .zero(z_w[2])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        string       name;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          lat_exp [3] = '{9, 33, 2};
    int          lat [3];
    int          ndone [3];
    logic [34:0] got [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [2:0] mop);
        logic [31:0] bi, r;
        logic [32:0] full;
        logic        v, set;
        bi   = mop[2] ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bi} + {32'd0, mop[2]};
        v    = (ma[31] == bi[31]) && (full[31] != ma[31]);
        set  = full[31] ^ v;
        case (mop[1:0])
            2'b00:   r = ma & bi;
            2'b01:   r = ma | bi;
            2'b10:   r = full[31:0];
            default: r = {31'd0, set};
        endcase
        return {r, full[32], v, (r == 32'd0)};
    endfunction

    // Accept one op on all instances, then watch 36 cycles; inject>0 pulses a stray start
    // into the DIGIT=4 instance only, sampled at edge 'inject'.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                          input int inject);
        @(negedge clk);
        check("ready before start", {61'd0, ready_w}, 64'd7);
        a = ta; b = tb; op = top; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        for (int d = 0; d < 3; d++) begin
            lat[d] = -1; ndone[d] = 0; got[d] = 'x;
        end
        for (int cyc = 1; cyc <= 36; cyc++) begin
            if (cyc == inject) begin
                start_x = 1'b1; a = 32'h1234_5678; b = 32'h0F0F_0F0F; op = 3'b000;
            end
            @(posedge clk);
            #1;
            start_x = 1'b0;
            if (cyc == 1) check("ready low while busy", {61'd0, ready_w}, 64'd0);
            for (int d = 0; d < 3; d++) begin
                if (done_w[d]) begin
                    ndone[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = cyc;
                        got[d] = {r_w[d], c_w[d], v_w[d], z_w[d]};
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s R/c/V/zero d%0d", tag, d),
                  {29'd0, r_w[d], c_w[d], v_w[d], z_w[d]}, {29'd0, 32'd0, 1'b0, 1'b0, 1'b1});
        end
        check({tag, " done"}, {61'd0, done_w}, 64'd0);
    endtask

    vec_t tbl [8];
    int   dones_after;

    initial begin
        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf"};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_zero"};
        tbl[2] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b1, 1'b0, 1'b0, "and"};
        tbl[3] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b1, 1'b0, 1'b0, "or"};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "slt_ovf"};
        tbl[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b0, 1'b0, 1'b1, "slt_zero"};
        tbl[6] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'b100, 32'hF0F0_0000, 1'b1, 1'b0, 1'b0, "andn"};
        tbl[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000, 1'b0, 1'b0, 1'b1, "orn"};

        reset = 1'b1; start = 1'b0; start_x = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("ready during reset", {61'd0, ready_w}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready after reset", {61'd0, ready_w}, 64'd7);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, 0);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("%s result d%0d", tbl[i].name, d), {29'd0, got[d]},
                      {29'd0, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z});
                check($sformatf("%s latency d%0d", tbl[i].name, d), 64'(lat[d]), 64'(lat_exp[d]));
                check($sformatf("%s done count d%0d", tbl[i].name, d), 64'(ndone[d]), 64'd1);
            end
        end

        // Stray start during RUN must be ignored by the DIGIT=4 instance.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 4);
        check("stray start result", {29'd0, got[0]}, {29'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        check("stray start latency", 64'(lat[0]), 64'd9);
        check("stray start done count", 64'(ndone[0]), 64'd1);

        // Reset while DIGIT=4 instance is on digit 3: no done, outputs back to reset values.
        @(negedge clk);
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; op = 3'b010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrun reset");
        check("ready in midrun reset", {61'd0, ready_w}, 64'd0);
        reset = 1'b0;
        #1;
        check("ready after midrun reset", {61'd0, ready_w}, 64'd7);
        dones_after = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done_w != 3'b000) dones_after++;
        end
        check("no done after midrun reset", 64'(dones_after), 64'd0);
        check_reset_outputs("after midrun reset");

        for (int i = 0; i < 800; i++) begin
            logic [31:0] ra, rb;
            logic [2:0]  ro;
            logic [34:0] exp;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            if (i % 16 == 3) ra = 32'h8000_0000;
            if (i % 16 == 5) rb = 32'h7FFF_FFFF;
            ro = 3'($urandom_range(0, 7));
            run_op(ra, rb, ro, 0);
            exp = model(ra, rb, ro);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("random %0d op%0d a=%h b=%h d%0d", i, ro, ra, rb, d),
                      {29'd0, got[d]}, {29'd0, exp});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "watchdog");
    end

endmodule
